mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers for the next-generation (pipelined) MIPS core.
- Sits beside the ALU in the EX stage.
- Accepts one operation at a time and models fixed multi-cycle latency with a busy flag.
- The pipeline uses busy to stall mfhi/mflo and any new MDU instruction.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation selected by op.
- op  input  3  0=mult 1=multu 2=div 3=divu 4=madd 5=maddu 6=msub 7=msubu.
- a  input  WIDTH  operand rs.
- b  input  WIDTH  operand rt.
- hi_we  input  1  mthi: write wdata to HI.
- lo_we  input  1  mtlo: write wdata to LO.
- wdata  input  WIDTH  mthi/mtlo data.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; no HI/LO update follows.
- FSM states: IDLE, RUN.
- IDLE + start with a valid op:
  - latch the 2*WIDTH result computed from a, b, op and current {HI,LO};
  - load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES);
  - go to RUN.
- Latency: start sampled at edge T gives busy=1 for edges T+1..T+N. At edge T+N, HI/LO take the result and busy falls. New values are visible in the cycle after busy drops.
- RUN: counter decrements each cycle. At counter==0, commit HI/LO and return to IDLE. start, hi_we and lo_we are ignored in RUN; the pipeline guarantees stall.
- Arithmetic, with all results truncated to WIDTH per register:
  - mult: signed product. multu: unsigned product. HI=upper WIDTH bits, LO=lower WIDTH bits.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Boundaries:
  - Divide by zero: runs the full DIV_CYCLES; HI/LO unchanged at commit.
  - Signed MIN / -1: LO=MIN, HI=0.
- Simultaneous events in IDLE:
  - start has priority over hi_we/lo_we; the writes are dropped.
  - hi_we and lo_we together write both registers.
  - mthi/mtlo take effect at the next edge, no latency.
- op 4-7 without the optional feature: start is ignored and the unit stays IDLE with busy=0.
- HI/LO outputs are registers only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 4-7 are valid, with latency MULT_CYCLES.
  - madd: {HI,LO} += signed a*b.
  - maddu: {HI,LO} += unsigned a*b.
  - msub/msubu subtract instead.
  - The accumulator operand is the {HI,LO} value at the start edge; arithmetic is modulo 2^(2*WIDTH).
- Undefined: ops 4-7 are treated as invalid (start ignored). No accumulate logic is synthesised.

Decomposition:
- Package mdu_pkg: op encodings (MDU_MULT…MDU_MSUBU), IDLE/RUN state encoding, default WIDTH.
- Sub-module mdu_arith: purely combinational (op, a, b, hi, lo) -> {res_hi, res_lo, div_by_zero}.
- mdu_unit holds the FSM, counter, pending result and HI/LO.

Test Plan:
- mult with a=0xFFFFFFFF (-1), b=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu a=7, b=2 -> LO=3, HI=1.
- Prior HI=0x11, LO=0x22; div by b=0 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged. div 0x80000000/-1 -> LO=0x80000000, HI=0.
- start mult, assert reset at the third busy cycle -> next cycle busy=0, HI=LO=0; no later commit.
- IDLE: hi_we=1, wdata=0xABCD -> HI=0xABCD next cycle. hi_we with start in the same cycle -> HI gets the mult result only. hi_we during RUN -> ignored.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu a=1, b=1 -> HI=1, LO=0 after 5 cycles. Without the macro: op=4 start -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation encodings, FSM state encoding and defaults shared by the
// multiply/divide unit. Optional accumulate ops are enabled by MDU_MADD_EN.
package mdu_pkg;

  localparam int MDU_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5,
    MDU_MSUB  = 3'd6,
    MDU_MSUBU = 3'd7
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // An op is launchable only if this build implements it.
  function automatic logic op_valid(input mdu_op_e op);
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
`endif
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational datapath producing the 2*WIDTH HI/LO result
// for a given op. Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH_DEF
) (
  input  mdu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o,
  output logic             div_by_zero_o
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    a_sx, b_sx, a_zx, b_zx;
  logic [W2-1:0]    prod_s, prod_u, acc, res;
  logic             b_zero, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, div_s, div_u;
  logic [WIDTH-1:0] q_s_mag, r_s_mag, q_s, r_s, q_u, r_u;

  // Products are taken at 2*WIDTH; modulo arithmetic makes the sign-extended
  // product equal to the signed product.
  assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign a_zx   = {{WIDTH{1'b0}}, a_i};
  assign b_zx   = {{WIDTH{1'b0}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi_i, lo_i};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. MIN / -1 falls out as LO=MIN, HI=0.
  assign b_zero  = (b_i == '0);
  assign a_neg   = a_i[WIDTH-1];
  assign b_neg   = b_i[WIDTH-1];
  assign a_mag   = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag   = b_neg ? (~b_i + 1'b1) : b_i;
  // Divisor forced to 1 on zero so the dividers never see an undefined case.
  assign div_s   = b_zero ? WIDTH'(1) : b_mag;
  assign div_u   = b_zero ? WIDTH'(1) : b_i;
  assign q_s_mag = a_mag / div_s;
  assign r_s_mag = a_mag % div_s;
  assign q_s     = (a_neg ^ b_neg) ? (~q_s_mag + 1'b1) : q_s_mag;
  assign r_s     = a_neg ? (~r_s_mag + 1'b1) : r_s_mag;
  assign q_u     = a_i / div_u;
  assign r_u     = a_i % div_u;

  // Result select by op; unchanged HI/LO is the fallback.
  always_comb begin
    res           = acc;
    div_by_zero_o = 1'b0;
    case (op_i)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (b_zero) div_by_zero_o = 1'b1;
        else        res = {r_s, q_s};
      end
      MDU_DIVU: begin
        if (b_zero) div_by_zero_o = 1'b1;
        else        res = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = acc + prod_s;
      MDU_MADDU: res = acc + prod_u;
      MDU_MSUB:  res = acc - prod_s;
      MDU_MSUBU: res = acc - prod_u;
`endif
      default:   res = acc;
    endcase
  end

  assign res_hi_o = res[W2-1:WIDTH];
  assign res_lo_o = res[WIDTH-1:0];

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Optional madd/maddu/msub/msubu support is compiled in with MDU_MADD_EN.
//
// Handshake: start is accepted only in IDLE (busy=0) with an op this build
// implements; the result is computed and held at that edge. busy is then high
// for exactly N cycles, HI/LO update on the edge where busy falls, and
// start/hi_we/lo_we are ignored while busy=1 (the pipeline stalls on busy).
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH_DEF,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_e       state_o
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  mdu_op_e            op_e;
  logic [WIDTH-1:0]   ar_hi, ar_lo;
  logic               ar_dbz;

  assign op_e = mdu_op_e'(op);

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op_i          (op_e),
    .a_i           (a),
    .b_i           (b),
    .hi_i          (hi_q),
    .lo_i          (lo_q),
    .res_hi_o      (ar_hi),
    .res_lo_o      (ar_lo),
    .div_by_zero_o (ar_dbz)
  );

  // Next-state: launch/mthi/mtlo in IDLE, count down and commit in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && op_valid(op_e)) begin
          res_d   = {ar_hi, ar_lo};
          dbz_d   = ar_dbz;
          cnt_d   = op_is_div(op_e) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          state_d = RUN;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (!dbz_q) begin
            hi_d = res_q[2*WIDTH-1:WIDTH];
            lo_d = res_q[WIDTH-1:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed plus random checks of mdu_unit with a result
// scoreboard. Accumulate checks follow MDU_MADD_EN.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         hi_we, lo_we;
  logic         busy;
  logic [W-1:0] hi, lo;
  mdu_state_e   state_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .state_o (state_o)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count remaining busy cycles (bounded) and compare with the expected count.
  task automatic wait_idle(input string tag, input int n_exp);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(cnt), 64'(n_exp));
  endtask

  task automatic commit_check(input string tag);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 64'(1), 64'(0));
    end else begin
      e = exp_q.pop_front();
      check({tag, " hi_lo"}, {hi, lo}, e);
    end
  endtask

  // Driver: launch one op at a negedge, optionally with a colliding mthi.
  task automatic run_op(input string tag, input logic [2:0] op_v,
                        input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                        input int n_exp, input logic [2*W-1:0] exp_v,
                        input logic mt_hi, input logic [W-1:0] wd_v);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    hi_we = mt_hi; wdata = wd_v;
    exp_q.push_back(exp_v);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    wait_idle(tag, n_exp);
    commit_check(tag);
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
    hi_we = h; lo_we = l; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Reference model for ops 0-3 using native wide arithmetic.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              ix, iy, q, r;
    logic [2*W-1:0]  m;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = {32'd0, x};           uy = {32'd0, y};
    ix = $signed(x);           iy = $signed(y);
    case (o)
      3'd0:    m = sx * sy;
      3'd1:    m = ux * uy;
      3'd2:    begin q = ix / iy; r = ix % iy; m = {r, q}; end
      default: m = {x % y, x / y};
    endcase
    return m;
  endfunction

  initial begin
    logic [2:0]   r_op;
    logic [W-1:0] r_a, r_b;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset state", 64'(state_o), 64'(IDLE));

    run_op("mult -1*2", 3'd0, 32'hFFFF_FFFF, 32'd2, MC, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, '0);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, MC, 64'h0000_0001_FFFF_FFFE, 1'b0, '0);
    run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, DC, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, '0);
    run_op("divu 7/2", 3'd3, 32'd7, 32'd2, DC, 64'h0000_0001_0000_0003, 1'b0, '0);

    mt_write(1'b1, 1'b0, 32'h11);
    check("mthi", 64'(hi), 64'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    check("mtlo", 64'(lo), 64'h22);
    run_op("div by zero", 3'd2, 32'd100, 32'd0, DC, 64'h0000_0011_0000_0022, 1'b0, '0);
    run_op("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 64'h0000_0000_8000_0000, 1'b0, '0);

    // Reset asserted during the third busy cycle aborts the op.
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'(0));
    check("abort hi_lo", {hi, lo}, 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("abort no commit busy", 64'(busy), 64'(0));
    check("abort no commit hi_lo", {hi, lo}, 64'd0);

    mt_write(1'b1, 1'b0, 32'hABCD);
    check("mthi abcd", {hi, lo}, 64'h0000_ABCD_0000_0000);
    mt_write(1'b1, 1'b1, 32'h55);
    check("mthi+mtlo", {hi, lo}, 64'h0000_0055_0000_0055);

    run_op("start beats mthi", 3'd0, 32'd3, 32'd4, MC, 64'd12, 1'b1, 32'h1234);

    // mthi during RUN is ignored.
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    exp_q.push_back(64'd6);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0;
    wait_idle("mthi in run", MC - 2);
    commit_check("mthi in run");

`ifdef MDU_MADD_EN
    mt_write(1'b1, 1'b0, 32'h0);
    mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op("maddu", 3'd5, 32'd1, 32'd1, MC, 64'h0000_0001_0000_0000, 1'b0, '0);
    run_op("msub", 3'd6, 32'd2, 32'hFFFF_FFFF, MC, 64'h0000_0001_0000_0002, 1'b0, '0);
`else
    start = 1'b1; op = 3'd4; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("op4 ignored busy", 64'(busy), 64'(0));
    repeat (MC + 1) @(negedge clk);
    check("op4 ignored hi_lo", {hi, lo}, 64'd6);
`endif

    for (int i = 0; i < 6; i++) begin
      r_op = 3'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      if (r_op >= 3'd2 && r_b == '0) r_b = 32'd7;
      if (r_op == 3'd2 && r_b == 32'hFFFF_FFFF) r_b = 32'd3;
      run_op($sformatf("random %0d op%0d", i, r_op), r_op, r_a, r_b,
             (r_op >= 3'd2) ? DC : MC, model(r_op, r_a, r_b), 1'b0, '0);
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
